camera_capture: RTL and testbench
=================================

CAMERA_CAPTURE -- requirements
Module: camera_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 8, DVP byte width.
REQ-002 SHALL have parameter BYTES_PER_PIX, default 2, bytes per pixel; legal 1..4.
REQ-003 SHALL have parameter COL_W, default 10, column counter width.
REQ-004 SHALL have parameter ROW_W, default 10, row counter width.
REQ-005 SHALL have parameter VSYNC_POL, default 1, active level of i_vsync (1 = high-active).
REQ-006 SHALL have parameter SWAP_BYTES, default 0; 0 = first byte in MSBs, 1 = first byte in LSBs.
REQ-007 SHALL have ports, in order: i_clk in 1 pixel clock; i_rst_n in 1 asynchronous active-low reset.
REQ-008 SHALL have ports: i_enable in 1 capture enable; i_vsync in 1 frame sync; i_href in 1 line valid; i_data in DATA_W sensor byte.
REQ-009 SHALL have ports: o_valid out 1 pixel strobe; o_data out DATA_W*BYTES_PER_PIX pixel; o_col out COL_W; o_row out ROW_W.
REQ-010 SHALL have ports: o_sof out 1 first pixel of frame; o_eol out 1 line end; o_frame_done out 1; o_line_err out 1.
REQ-011 SHALL, with CAM_CAPTURE_CROP_EN defined, add ports i_crop_x0, i_crop_x1 in COL_W and i_crop_y0, i_crop_y1 in ROW_W.

Function
REQ-012 SHALL implement states IDLE, SYNC, WAIT_FRAME, CAPTURE; vsync "active" means i_vsync == VSYNC_POL.
REQ-013 IDLE -> SYNC when i_enable=1; SYNC -> WAIT_FRAME when vsync inactive; WAIT_FRAME -> CAPTURE when vsync active (no partial first frame).
REQ-014 CAPTURE -> WAIT_FRAME when vsync goes inactive, with o_frame_done pulsed exactly one cycle; -> IDLE instead if i_enable=0 at that cycle.
REQ-015 i_enable deasserting mid-frame SHALL take effect only at frame end; frame completes normally.
REQ-016 In CAPTURE with i_href=1, bytes SHALL be sampled every cycle into a byte counter 0..BYTES_PER_PIX-1, byte k placed per SWAP_BYTES.
REQ-017 On the cycle the last byte is sampled, o_valid SHALL pulse the following cycle (latency 1) with o_data, o_col, o_row of that pixel stable while o_valid=1.
REQ-018 o_col SHALL start at 0 each line, increment after each pixel, saturate at all-ones.
REQ-019 On i_href falling (1->0) in CAPTURE with >=1 pixel in line: o_eol pulses one cycle, o_row increments (saturating), o_col resets to 0.
REQ-020 On i_href falling with byte counter != 0: partial pixel discarded, no o_valid, o_line_err pulses one cycle; byte counter cleared.
REQ-021 i_href dropping and vsync going inactive in the same cycle SHALL produce o_eol/o_line_err as applicable and o_frame_done in the same cycle.
REQ-022 o_sof SHALL be high with o_valid on the first emitted pixel of each frame only.
REQ-023 o_row and o_col SHALL clear on entry to CAPTURE; o_data holds last value when o_valid=0.
REQ-024 i_href outside CAPTURE SHALL be ignored.

Reset
REQ-025 i_rst_n=0 SHALL asynchronously force state IDLE and all outputs, counters, byte counter to 0.
REQ-026 Reset deassertion mid-frame SHALL require a full SYNC/WAIT_FRAME sequence before capture.

Configuration
REQ-027 Macro CAM_CAPTURE_CROP_EN defined: o_valid only for x0<=col<=x1 and y0<=row<=y1 (inclusive, raw coordinates on o_col/o_row); o_sof on first in-window pixel; o_eol only for lines within y0..y1.
REQ-028 Macro undefined: crop ports absent, every pixel emitted.

Verification
REQ-029 Defaults, enable, vsync 0->1, href 4 cycles bytes 0xAB,0xCD,0x12,0x34 -> o_valid twice: 0xABCD col0 sof=1, 0x1234 col1 sof=0; then o_eol, row=1.
REQ-030 SWAP_BYTES=1, same bytes -> 0xCDAB, 0x3412.
REQ-031 href 3 cycles (odd, BYTES_PER_PIX=2) -> one pixel, then o_line_err pulse, no second o_valid.
REQ-032 Enable asserted while vsync active mid-frame -> no o_valid until vsync inactive then active; o_frame_done one cycle at next vsync fall.
REQ-033 CROP_EN, x0=1,x1=2,y0=1,y1=1, 3 lines x 4 pixels -> exactly 2 o_valid, (row1,col1) with sof=1 and (row1,col2).
REQ-034 i_rst_n pulsed low mid-line -> outputs 0 immediately; no o_valid until next full frame start.

Source files
------------

// File: rtl/camera_capture.sv
// camera_capture: assembles DVP sensor bytes into pixels with column/row tracking and frame framing.
// Optional crop window (i_crop_x0/x1/y0/y1 ports) when CAM_CAPTURE_CROP_EN is defined.
module camera_capture #(
    parameter int   DATA_W        = 8,
    parameter int   BYTES_PER_PIX = 2,
    parameter int   COL_W         = 10,
    parameter int   ROW_W         = 10,
    parameter logic VSYNC_POL     = 1'b1,
    parameter int   SWAP_BYTES    = 0
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_enable,
    input  logic                            i_vsync,
    input  logic                            i_href,
    input  logic [DATA_W-1:0]               i_data,
    output logic                            o_valid,
    output logic [DATA_W*BYTES_PER_PIX-1:0] o_data,
    output logic [COL_W-1:0]                o_col,
    output logic [ROW_W-1:0]                o_row,
    output logic                            o_sof,
    output logic                            o_eol,
    output logic                            o_frame_done,
    output logic                            o_line_err
`ifdef CAM_CAPTURE_CROP_EN
    ,
    input  logic [COL_W-1:0]                i_crop_x0,
    input  logic [COL_W-1:0]                i_crop_x1,
    input  logic [ROW_W-1:0]                i_crop_y0,
    input  logic [ROW_W-1:0]                i_crop_y1
`endif
);

    // state      | meaning
    // IDLE       | capture disabled
    // SYNC       | enabled, waiting for vsync inactive (never join a frame midway)
    // WAIT_FRAME | between frames, waiting for vsync active
    // CAPTURE    | inside a frame, sampling bytes while href is high
    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_SYNC       = 2'd1;
    localparam logic [1:0] ST_WAIT_FRAME = 2'd2;
    localparam logic [1:0] ST_CAPTURE    = 2'd3;

    localparam int PIX_W  = DATA_W * BYTES_PER_PIX;
    localparam int BCNT_W = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BYTES_PER_PIX - 1);

    logic [1:0]        state;
    logic [BCNT_W-1:0] bcnt;
    logic [PIX_W-1:0]  asm_q;
    logic [PIX_W-1:0]  pix_next;
    logic [COL_W-1:0]  col_cnt;
    logic [COL_W-1:0]  col_inc;
    logic [ROW_W-1:0]  row_cnt;
    logic [ROW_W-1:0]  row_inc;
    logic              href_d;
    logic              sof_pend;
    int                byte_pos;

    logic vs_act;
    logic in_capture;
    logic sample;
    logic pix_done;
    logic line_end;
    logic col_in_win;
    logic row_in_win;
    logic pix_emit;

    assign vs_act     = (i_vsync == VSYNC_POL);
    assign in_capture = (state == ST_CAPTURE);
    assign sample     = in_capture & vs_act & i_href;
    assign pix_done   = sample & (bcnt == BCNT_LAST);
    // A line also ends if the frame closes while href is still high.
    assign line_end   = in_capture & href_d & (~i_href | ~vs_act);

    assign col_inc = (col_cnt == '1) ? col_cnt : col_cnt + 1'b1;
    assign row_inc = (row_cnt == '1) ? row_cnt : row_cnt + 1'b1;

`ifdef CAM_CAPTURE_CROP_EN
    assign col_in_win = (col_cnt >= i_crop_x0) && (col_cnt <= i_crop_x1);
    assign row_in_win = (row_cnt >= i_crop_y0) && (row_cnt <= i_crop_y1);
`else
    assign col_in_win = 1'b1;
    assign row_in_win = 1'b1;
`endif

    assign pix_emit = pix_done & col_in_win & row_in_win;

    // Merge the incoming byte into the pixel being assembled so the last byte
    // is available in the same cycle it is sampled.
    always_comb begin
        if (SWAP_BYTES != 0) begin
            byte_pos = int'(bcnt);
        end else begin
            byte_pos = BYTES_PER_PIX - 1 - int'(bcnt);
        end
        pix_next = asm_q;
        pix_next[byte_pos*DATA_W +: DATA_W] = i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            bcnt         <= '0;
            asm_q        <= '0;
            col_cnt      <= '0;
            row_cnt      <= '0;
            href_d       <= 1'b0;
            sof_pend     <= 1'b0;
            o_valid      <= 1'b0;
            o_data       <= '0;
            o_col        <= '0;
            o_row        <= '0;
            o_sof        <= 1'b0;
            o_eol        <= 1'b0;
            o_frame_done <= 1'b0;
            o_line_err   <= 1'b0;
        end else begin
            o_valid      <= 1'b0;
            o_sof        <= 1'b0;
            o_eol        <= 1'b0;
            o_frame_done <= 1'b0;
            o_line_err   <= 1'b0;
            href_d       <= i_href;

            case (state)
                ST_IDLE: begin
                    if (i_enable) state <= ST_SYNC;
                end
                ST_SYNC: begin
                    if (!i_enable) begin
                        state <= ST_IDLE;
                    end else if (!vs_act) begin
                        state <= ST_WAIT_FRAME;
                    end
                end
                ST_WAIT_FRAME: begin
                    if (!i_enable) begin
                        state <= ST_IDLE;
                    end else if (vs_act) begin
                        state    <= ST_CAPTURE;
                        bcnt     <= '0;
                        col_cnt  <= '0;
                        row_cnt  <= '0;
                        o_col    <= '0;
                        o_row    <= '0;
                        sof_pend <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    // Enable is only honoured here, so a running frame always completes.
                    if (!vs_act) begin
                        o_frame_done <= 1'b1;
                        state        <= i_enable ? ST_WAIT_FRAME : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (sample) begin
                asm_q <= pix_next;
                if (pix_done) begin
                    bcnt    <= '0;
                    col_cnt <= col_inc;
                end else begin
                    bcnt <= bcnt + 1'b1;
                end
            end

            if (pix_emit) begin
                o_valid  <= 1'b1;
                o_data   <= pix_next;
                o_col    <= col_cnt;
                o_row    <= row_cnt;
                o_sof    <= sof_pend;
                sof_pend <= 1'b0;
            end

            if (line_end) begin
                bcnt <= '0;
                if (bcnt != '0) o_line_err <= 1'b1;
                if (col_cnt != '0) begin
                    col_cnt <= '0;
                    row_cnt <= row_inc;
                    o_col   <= '0;
                    o_row   <= row_inc;
                    if (row_in_win) o_eol <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_camera_capture.sv
// Bench for camera_capture: directed scenarios plus random frames against a line/pixel reference model.
// Build with CAM_CAPTURE_CROP_EN defined to also exercise the crop window.
module tb_camera_capture;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       enable  = 1'b0;
    logic       vsync   = 1'b0;
    logic       href    = 1'b0;
    logic [7:0] data    = 8'h00;

    logic        valid, sof, eol, fdone, lerr;
    logic [15:0] odata;
    logic [9:0]  col, row;
    logic        valid_s, sof_s, eol_s, fdone_s, lerr_s;
    logic [15:0] odata_s;
    logic [9:0]  col_s, row_s;

`ifdef CAM_CAPTURE_CROP_EN
    logic [9:0] cx0 = 10'd0, cx1 = 10'h3ff, cy0 = 10'd0, cy1 = 10'h3ff;
`endif

    camera_capture u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_vsync(vsync),
        .i_href(href), .i_data(data),
        .o_valid(valid), .o_data(odata), .o_col(col), .o_row(row),
        .o_sof(sof), .o_eol(eol), .o_frame_done(fdone), .o_line_err(lerr)
`ifdef CAM_CAPTURE_CROP_EN
        , .i_crop_x0(cx0), .i_crop_x1(cx1), .i_crop_y0(cy0), .i_crop_y1(cy1)
`endif
    );

    camera_capture #(.SWAP_BYTES(1)) u_swap (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_vsync(vsync),
        .i_href(href), .i_data(data),
        .o_valid(valid_s), .o_data(odata_s), .o_col(col_s), .o_row(row_s),
        .o_sof(sof_s), .o_eol(eol_s), .o_frame_done(fdone_s), .o_line_err(lerr_s)
`ifdef CAM_CAPTURE_CROP_EN
        , .i_crop_x0(cx0), .i_crop_x1(cx1), .i_crop_y0(cy0), .i_crop_y1(cy1)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic [9:0]  c;
        logic [9:0]  r;
        logic        s;
    } pix_t;

    // observations (written only by the monitor)
    pix_t        obs_pix[$];
    logic [15:0] obs_swap[$];
    logic [9:0]  eol_rows[$];
    int n_err   = 0;
    int n_fd    = 0;
    int n_coinc = 0;

    always @(negedge clk) begin
        if (valid) obs_pix.push_back('{odata, col, row, sof});
        if (valid_s) obs_swap.push_back(odata_s);
        if (eol) eol_rows.push_back(row);
        if (lerr) n_err++;
        if (fdone) n_fd++;
        if (fdone && eol && lerr) n_coinc++;
    end

    // stimulus description and reference expectations
    int          line_len[$];
    logic [7:0]  line_bytes[$];
    pix_t        exp_pix[$];
    logic [15:0] exp_swap[$];
    logic [9:0]  exp_eol[$];
    int          exp_err;

    int checks   = 0;
    int failures = 0;
    int sp, ss, se, sr, sf, sc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic snap();
        sp = obs_pix.size();
        ss = obs_swap.size();
        se = eol_rows.size();
        sr = n_err;
        sf = n_fd;
        sc = n_coinc;
    endtask

    function automatic pix_t get_obs(input int i);
        if (i < obs_pix.size()) return obs_pix[i];
        return '0;
    endfunction

    function automatic logic [15:0] get_swap(input int i);
        if (i < obs_swap.size()) return obs_swap[i];
        return '0;
    endfunction

    function automatic logic [9:0] get_eol(input int i);
        if (i < eol_rows.size()) return eol_rows[i];
        return '0;
    endfunction

    function automatic bit in_win(input int c, input int r);
`ifdef CAM_CAPTURE_CROP_EN
        return (c >= int'(cx0)) && (c <= int'(cx1)) && (r >= int'(cy0)) && (r <= int'(cy1));
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit row_win(input int r);
`ifdef CAM_CAPTURE_CROP_EN
        return (r >= int'(cy0)) && (r <= int'(cy1));
`else
        return 1'b1;
`endif
    endfunction

    // Model: each line contributes floor(len/2) pixels, first byte high (low when swapped);
    // rows count only lines that produced a pixel; odd lengths leave a discarded byte.
    task automatic build_expected();
        int  idx = 0;
        int  r   = 0;
        bit  first = 1'b1;
        exp_pix.delete();
        exp_swap.delete();
        exp_eol.delete();
        exp_err = 0;
        for (int l = 0; l < line_len.size(); l++) begin
            int np = line_len[l] / 2;
            for (int k = 0; k < np; k++) begin
                logic [7:0] b0 = line_bytes[idx + 2*k];
                logic [7:0] b1 = line_bytes[idx + 2*k + 1];
                if (in_win(k, r)) begin
                    exp_pix.push_back('{{b0, b1}, 10'(k), 10'(r), first});
                    exp_swap.push_back({b1, b0});
                    first = 1'b0;
                end
            end
            if ((line_len[l] % 2) != 0) exp_err++;
            if (np > 0) begin
                if (row_win(r)) exp_eol.push_back(10'(r + 1));
                r++;
            end
            idx += line_len[l];
        end
    endtask

    task automatic drive_frame(input bit coincident, input int drop_en_line);
        int idx = 0;
        vsync = 1'b0; href = 1'b0;
        idle(3);
        vsync = 1'b1;
        idle(2);
        for (int l = 0; l < line_len.size(); l++) begin
            if (l == drop_en_line) enable = 1'b0;
            href = 1'b1;
            for (int b = 0; b < line_len[l]; b++) begin
                data = line_bytes[idx];
                idx++;
                tick();
            end
            href = 1'b0;
            if (coincident && (l == line_len.size() - 1)) begin
                vsync = 1'b0;
                tick();
            end else begin
                idle(2);
            end
        end
        vsync = 1'b0;
        idle(4);
    endtask

    task automatic compare_frame(input string tag, input bit active);
        int np = active ? exp_pix.size() : 0;
        int ne = active ? exp_eol.size() : 0;
        chk({tag, ".npix"}, obs_pix.size() - sp, np);
        chk({tag, ".nswap"}, obs_swap.size() - ss, np);
        for (int i = 0; i < np; i++) begin
            pix_t o = get_obs(sp + i);
            chk({tag, ".data"}, o.d, exp_pix[i].d);
            chk({tag, ".col"}, o.c, exp_pix[i].c);
            chk({tag, ".row"}, o.r, exp_pix[i].r);
            chk({tag, ".sof"}, o.s, exp_pix[i].s);
            chk({tag, ".swap"}, get_swap(ss + i), exp_swap[i]);
        end
        chk({tag, ".neol"}, eol_rows.size() - se, ne);
        for (int i = 0; i < ne; i++) chk({tag, ".eolrow"}, get_eol(se + i), exp_eol[i]);
        chk({tag, ".lerr"}, n_err - sr, active ? exp_err : 0);
        chk({tag, ".fdone"}, n_fd - sf, active ? 1 : 0);
    endtask

    task automatic set_line(input int len);
        line_len.push_back(len);
        for (int b = 0; b < len; b++) line_bytes.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic clear_lines();
        line_len.delete();
        line_bytes.delete();
    endtask

    initial begin
        pix_t o;

        // reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst.valid", valid, 1'b0);
        chk("rst.data", odata, 16'h0);
        chk("rst.col", col, 10'd0);
        chk("rst.row", row, 10'd0);
        chk("rst.sof", sof, 1'b0);
        chk("rst.eol", eol, 1'b0);
        chk("rst.fdone", fdone, 1'b0);
        chk("rst.lerr", lerr, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        enable = 1'b1;

        // two pixels, MSB-first and swapped
        clear_lines();
        line_len.push_back(4);
        line_bytes.push_back(8'hAB); line_bytes.push_back(8'hCD);
        line_bytes.push_back(8'h12); line_bytes.push_back(8'h34);
        build_expected();
        snap();
        drive_frame(1'b0, -1);
        compare_frame("basic", 1'b1);
        o = get_obs(sp);
        chk("basic.d0", o.d, 16'hABCD);
        chk("basic.c0", o.c, 10'd0);
        chk("basic.sof0", o.s, 1'b1);
        o = get_obs(sp + 1);
        chk("basic.d1", o.d, 16'h1234);
        chk("basic.c1", o.c, 10'd1);
        chk("basic.sof1", o.s, 1'b0);
        chk("basic.eolrow", get_eol(se), 10'd1);
        chk("basic.swap0", get_swap(ss), 16'hCDAB);
        chk("basic.swap1", get_swap(ss + 1), 16'h3412);
        chk("basic.hold", odata, 16'h1234);

        // odd-length line: one pixel plus line error
        clear_lines();
        set_line(3);
        build_expected();
        snap();
        drive_frame(1'b0, -1);
        compare_frame("odd", 1'b1);
        chk("odd.n", obs_pix.size() - sp, 1);
        chk("odd.lerr", n_err - sr, 1);

        // random frames
        for (int f = 0; f < 6; f++) begin
            clear_lines();
            for (int l = 0; l < int'($urandom_range(1, 4)); l++) set_line($urandom_range(1, 9));
            build_expected();
            snap();
            drive_frame(1'b0, -1);
            compare_frame("rand", 1'b1);
        end

        // href drop coincident with vsync fall
        clear_lines();
        set_line(4);
        set_line(5);
        build_expected();
        snap();
        drive_frame(1'b1, -1);
        compare_frame("coinc", 1'b1);
        chk("coinc.same_cycle", n_coinc - sc, 1);

        // enable dropped mid-frame: frame still completes, next frame ignored
        clear_lines();
        set_line(6); set_line(4); set_line(2);
        build_expected();
        snap();
        drive_frame(1'b0, 1);
        compare_frame("en_drop", 1'b1);
        snap();
        drive_frame(1'b0, -1);
        compare_frame("disabled", 1'b0);

        // enable while vsync already active: that frame is skipped
        vsync = 1'b1;
        idle(2);
        enable = 1'b1;
        snap();
        href = 1'b1;
        for (int b = 0; b < 4; b++) begin
            data = 8'($urandom_range(0, 255));
            tick();
        end
        href = 1'b0;
        idle(2);
        vsync = 1'b0;
        idle(4);
        chk("late_en.npix", obs_pix.size() - sp, 0);
        chk("late_en.fdone", n_fd - sf, 0);
        clear_lines();
        set_line(4); set_line(6);
        build_expected();
        snap();
        drive_frame(1'b0, -1);
        compare_frame("late_en.next", 1'b1);

        // reset pulsed mid-line
        vsync = 1'b0; href = 1'b0;
        idle(3);
        vsync = 1'b1;
        idle(2);
        href = 1'b1;
        data = 8'hAB; tick();
        data = 8'hCD; tick();
        chk("mrst.pre_valid", valid, 1'b1);
        chk("mrst.pre_data", odata, 16'hABCD);
        data = 8'h12;
        rst_n = 1'b0;
        #1;
        chk("mrst.valid", valid, 1'b0);
        chk("mrst.data", odata, 16'h0);
        chk("mrst.col", col, 10'd0);
        chk("mrst.row", row, 10'd0);
        #2 rst_n = 1'b1;
        snap();
        for (int b = 0; b < 4; b++) begin
            data = 8'($urandom_range(0, 255));
            tick();
        end
        href = 1'b0;
        idle(2);
        vsync = 1'b0;
        idle(1);
        chk("mrst.npix", obs_pix.size() - sp, 0);
        chk("mrst.fdone", n_fd - sf, 0);
        clear_lines();
        set_line(4);
        build_expected();
        snap();
        drive_frame(1'b0, -1);
        compare_frame("mrst.next", 1'b1);

`ifdef CAM_CAPTURE_CROP_EN
        // crop window x 1..2, y 1..1 over 3 lines of 4 pixels
        cx0 = 10'd1; cx1 = 10'd2; cy0 = 10'd1; cy1 = 10'd1;
        clear_lines();
        set_line(8); set_line(8); set_line(8);
        build_expected();
        snap();
        drive_frame(1'b0, -1);
        compare_frame("crop", 1'b1);
        chk("crop.n", obs_pix.size() - sp, 2);
        o = get_obs(sp);
        chk("crop.r0", o.r, 10'd1);
        chk("crop.c0", o.c, 10'd1);
        chk("crop.sof0", o.s, 1'b1);
        o = get_obs(sp + 1);
        chk("crop.c1", o.c, 10'd2);
        chk("crop.sof1", o.s, 1'b0);
        cx0 = 10'd0; cx1 = 10'h3ff; cy0 = 10'd0; cy1 = 10'h3ff;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
